// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder:
// FSM state encoding, slice width and counter sizing helper.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  // A one-nibble adder still needs a 1-bit counter so the select logic stays uniform.
  function automatic int cnt_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/pg_slice.sv
// Combinational 4-bit carry-lookahead slice: generate/propagate terms,
// lookahead carries c[4:1] and the nibble sum.
module pg_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                c0,
  output logic [NIBBLE_W-1:0] s4,
  output logic [4:1]          c
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;

  always_comb begin
    p    = a4 ^ b4;
    g    = a4 & b4;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    s4   = p ^ {c[3:1], c0};
  end

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle adder: one 4-bit lookahead slice is reused once per nibble,
// LS nibble first, with a carry register chaining the nibbles together.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_width(NIB);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                carry_q, carry_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;

  logic [CW+1:0]       nib_idx;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic [4:1]          c_nib;

  // Bit offset of the active nibble is simply counter*4.
  assign nib_idx = {cnt_q, 2'b00};
  assign a_nib   = a_q[nib_idx +: NIBBLE_W];
  assign b_nib   = b_q[nib_idx +: NIBBLE_W];

  pg_slice u_pg_slice (
    .a4 (a_nib),
    .b4 (b_nib),
    .c0 (carry_q),
    .s4 (s_nib),
    .c  (c_nib)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[nib_idx +: NIBBLE_W] = s_nib;
        carry_d = c_nib[4];
        cnt_d   = cnt_q + CW'(1);
        // Final nibble carries the MSB, so its C3/C4 give cout and signed overflow.
        if (cnt_q == CW'(NIB - 1)) begin
          cout_d      = c_nib[4];
          ovf_d       = c_nib[3] ^ c_nib[4];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
